// File: rtl/hazard_tracker_pkg.sv
// Shared definitions for the hazard tracker, forwarding unit and register file.
// Holds the default register width, the $0 index and the per-edge pipeline action.
package hazard_tracker_pkg;

  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 16;

  // Register $0 is hard-wired; a write to it is never tracked as a real write.
  localparam logic [REG_W_DEF-1:0] REG_ZERO = '0;

  // A bubble is an all-zero stage entry: no write, no load, all register IDs 0.
  typedef enum logic [1:0] {
    OP_ADVANCE = 2'd0,
    OP_FLUSH   = 2'd1,
    OP_LOADUSE = 2'd2,
    OP_FREEZE  = 2'd3
  } stage_op_e;

endpackage

// File: rtl/hazard_tracker_if.sv
// Bus between the decode stage / forwarding unit and the hazard tracker.
// slave = tracker side, master = pipeline side driving the ID-stage fields.
interface hazard_tracker_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] IFID_RegRS_i;
  logic [REG_W-1:0] IFID_RegRT_i;
  logic [REG_W-1:0] ID_RegDst_i;
  logic             ID_RegWrite_i;
  logic             ID_MemRead_i;
  logic             Flush_i;
  logic             MemStall_i;
  logic [REG_W-1:0] IDEX_RegRS_o;
  logic [REG_W-1:0] IDEX_RegRT_o;
  logic             EXMEM_RegWrite_o;
  logic [REG_W-1:0] EXMEM_RegRD_o;
  logic             MEMWB_RegWrite_o;
  logic [REG_W-1:0] MEMWB_RegRD_o;
  logic             Stall_o;
  logic [CNT_W-1:0] LoadUseCnt_o;
  logic [CNT_W-1:0] MemStallCnt_o;

  modport slave (
    input  IFID_RegRS_i, IFID_RegRT_i, ID_RegDst_i, ID_RegWrite_i, ID_MemRead_i,
           Flush_i, MemStall_i,
    output IDEX_RegRS_o, IDEX_RegRT_o, EXMEM_RegWrite_o, EXMEM_RegRD_o,
           MEMWB_RegWrite_o, MEMWB_RegRD_o, Stall_o, LoadUseCnt_o, MemStallCnt_o
  );

  modport master (
    output IFID_RegRS_i, IFID_RegRT_i, ID_RegDst_i, ID_RegWrite_i, ID_MemRead_i,
           Flush_i, MemStall_i,
    input  IDEX_RegRS_o, IDEX_RegRT_o, EXMEM_RegWrite_o, EXMEM_RegRD_o,
           MEMWB_RegWrite_o, MEMWB_RegRD_o, Stall_o, LoadUseCnt_o, MemStallCnt_o
  );
endinterface

// File: rtl/hazard_tracker_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;
endmodule

// File: rtl/hazard_tracker.sv
// Carries destination-register info through ID/EX, EX/MEM, MEM/WB for the forwarding
// unit, detects load-use hazards, inserts bubbles and counts stall cycles.
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic             clk_i,
  input logic             rst_i,
  hazard_tracker_if.slave bus
);
  localparam logic [REG_W-1:0] W_ZERO = REG_W'(REG_ZERO);

  logic             r_idex_we;
  logic             r_idex_mr;
  logic [REG_W-1:0] r_idex_rd;
  logic [REG_W-1:0] r_idex_rs;
  logic [REG_W-1:0] r_idex_rt;
  logic             r_exmem_we;
  logic [REG_W-1:0] r_exmem_rd;
  logic             r_memwb_we;
  logic [REG_W-1:0] r_memwb_rd;

  logic             w_load_use;
  stage_op_e        w_op;
  logic [CNT_W-1:0] w_lu_cnt;
  logic [CNT_W-1:0] w_ms_cnt;

  assign w_load_use = r_idex_mr && (r_idex_rd != W_ZERO) &&
                      ((r_idex_rd == bus.IFID_RegRS_i) || (r_idex_rd == bus.IFID_RegRT_i));

  // Priority: memory freeze beats flush, flush beats load-use.
  always_comb begin
    w_op = OP_ADVANCE;
    if (bus.MemStall_i)   w_op = OP_FREEZE;
    else if (bus.Flush_i) w_op = OP_FLUSH;
    else if (w_load_use)  w_op = OP_LOADUSE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_idex_we  <= 1'b0;
      r_idex_mr  <= 1'b0;
      r_idex_rd  <= '0;
      r_idex_rs  <= '0;
      r_idex_rt  <= '0;
      r_exmem_we <= 1'b0;
      r_exmem_rd <= '0;
      r_memwb_we <= 1'b0;
      r_memwb_rd <= '0;
    end else if (w_op != OP_FREEZE) begin
      r_exmem_we <= r_idex_we;
      r_exmem_rd <= r_idex_rd;
      r_memwb_we <= r_exmem_we;
      r_memwb_rd <= r_exmem_rd;
      if (w_op == OP_ADVANCE) begin
        r_idex_we <= bus.ID_RegWrite_i && (bus.ID_RegDst_i != W_ZERO);
        r_idex_mr <= bus.ID_MemRead_i;
        r_idex_rd <= bus.ID_RegDst_i;
        r_idex_rs <= bus.IFID_RegRS_i;
        r_idex_rt <= bus.IFID_RegRT_i;
      end else begin
        r_idex_we <= 1'b0;
        r_idex_mr <= 1'b0;
        r_idex_rd <= '0;
        r_idex_rs <= '0;
        r_idex_rt <= '0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_op == OP_LOADUSE),
    .cnt_o (w_lu_cnt)
  );

  sat_counter #(.W(CNT_W)) u_ms_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_op == OP_FREEZE),
    .cnt_o (w_ms_cnt)
  );

  assign bus.IDEX_RegRS_o     = r_idex_rs;
  assign bus.IDEX_RegRT_o     = r_idex_rt;
  assign bus.EXMEM_RegWrite_o = r_exmem_we;
  assign bus.EXMEM_RegRD_o    = r_exmem_rd;
  assign bus.MEMWB_RegWrite_o = r_memwb_we;
  assign bus.MEMWB_RegRD_o    = r_memwb_rd;
  assign bus.Stall_o          = bus.MemStall_i | (w_load_use & ~bus.Flush_i);
  assign bus.LoadUseCnt_o     = w_lu_cnt;
  assign bus.MemStallCnt_o    = w_ms_cnt;
endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed scenarios then random traffic against a queue model.
module tb_hazard_tracker;
  import hazard_tracker_pkg::*;

  localparam int RW = 5;
  localparam int CW = 16;
  localparam int SW = 2;
  localparam int EW = 2 + 3 * RW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [RW-1:0] rs, rt, dst;
  logic          we, mr, fl, ms;

  hazard_tracker_if #(.REG_W(RW), .CNT_W(CW)) bus ();
  hazard_tracker_if #(.REG_W(RW), .CNT_W(SW)) bus_s ();

  hazard_tracker #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk_i (clk), .rst_i (rst_n), .bus (bus.slave)
  );
  hazard_tracker #(.REG_W(RW), .CNT_W(SW)) dut_s (
    .clk_i (clk), .rst_i (rst_n), .bus (bus_s.slave)
  );

  assign bus.IFID_RegRS_i   = rs;   assign bus_s.IFID_RegRS_i   = rs;
  assign bus.IFID_RegRT_i   = rt;   assign bus_s.IFID_RegRT_i   = rt;
  assign bus.ID_RegDst_i    = dst;  assign bus_s.ID_RegDst_i    = dst;
  assign bus.ID_RegWrite_i  = we;   assign bus_s.ID_RegWrite_i  = we;
  assign bus.ID_MemRead_i   = mr;   assign bus_s.ID_MemRead_i   = mr;
  assign bus.Flush_i        = fl;   assign bus_s.Flush_i        = fl;
  assign bus.MemStall_i     = ms;   assign bus_s.MemStall_i     = ms;

  // ---------------- scoreboard / model ----------------
  // exp_q[0] = ID/EX entry, [1] = EX/MEM, [2] = MEM/WB; entry = {we, mr, rd, rs, rt}
  logic [EW-1:0] exp_q[$];
  int unsigned   lu_cnt, ms_cnt;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q = {};
    repeat (3) exp_q.push_back('0);
    lu_cnt = 0;
    ms_cnt = 0;
  endtask

  function automatic logic model_lu();
    logic [EW-1:0] e;
    logic [RW-1:0] rd;
    e  = exp_q[0];
    rd = e[3*RW-1:2*RW];
    return e[EW-2] && (rd != 0) && (rd == rs || rd == rt);
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic check_outputs(input string tag);
    logic [EW-1:0] e0, e1, e2;
    e0 = exp_q[0]; e1 = exp_q[1]; e2 = exp_q[2];
    chk({tag, ":idex_rs"},   32'(bus.IDEX_RegRS_o),     32'(e0[2*RW-1:RW]));
    chk({tag, ":idex_rt"},   32'(bus.IDEX_RegRT_o),     32'(e0[RW-1:0]));
    chk({tag, ":exmem_we"},  32'(bus.EXMEM_RegWrite_o), 32'(e1[EW-1]));
    chk({tag, ":exmem_rd"},  32'(bus.EXMEM_RegRD_o),    32'(e1[3*RW-1:2*RW]));
    chk({tag, ":memwb_we"},  32'(bus.MEMWB_RegWrite_o), 32'(e2[EW-1]));
    chk({tag, ":memwb_rd"},  32'(bus.MEMWB_RegRD_o),    32'(e2[3*RW-1:2*RW]));
    chk({tag, ":lu_cnt"},    32'(bus.LoadUseCnt_o),     sat(lu_cnt, 65535));
    chk({tag, ":ms_cnt"},    32'(bus.MemStallCnt_o),    sat(ms_cnt, 65535));
    chk({tag, ":lu_cnt_s"},  32'(bus_s.LoadUseCnt_o),   sat(lu_cnt, 3));
    chk({tag, ":ms_cnt_s"},  32'(bus_s.MemStallCnt_o),  sat(ms_cnt, 3));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input int a_rs, input int a_rt, input int a_dst,
                        input bit a_we, input bit a_mr, input bit a_fl, input bit a_ms);
    rs = RW'(a_rs); rt = RW'(a_rt); dst = RW'(a_dst);
    we = a_we; mr = a_mr; fl = a_fl; ms = a_ms;
    #1;
  endtask

  // Checks the combinational stall, takes one clock edge, updates the model, checks state.
  task automatic step(input string tag);
    logic          lu;
    logic [EW-1:0] e;
    lu = model_lu();
    chk({tag, ":stall"}, 32'(bus.Stall_o), 32'(ms | (lu & ~fl)));
    @(posedge clk);
    if (ms) begin
      ms_cnt++;
    end else begin
      if (fl || lu) e = '0;
      else          e = {we && (dst != 0), mr, dst, rs, rt};
      if (!fl && lu) lu_cnt++;
      exp_q.push_front(e);
      void'(exp_q.pop_back());
    end
    #1;
    check_outputs(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check_outputs("reset");
    chk("reset:stall", 32'(bus.Stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // plain flow
    set_in(1, 2, 5, 1, 0, 0, 0); step("t1_a");
    set_in(0, 0, 0, 0, 0, 0, 0); step("t1_b");
    chk("t1_exmem_rd", 32'(bus.EXMEM_RegRD_o), 32'd5);
    chk("t1_exmem_we", 32'(bus.EXMEM_RegWrite_o), 32'd1);
    step("t1_c");
    chk("t1_memwb_rd", 32'(bus.MEMWB_RegRD_o), 32'd5);

    // writes to $0 never show as RegWrite
    set_in(3, 4, 0, 1, 0, 0, 0); step("t2_a");
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("t2_n");
      chk("t2_exmem_we", 32'(bus.EXMEM_RegWrite_o), 32'd0);
      chk("t2_memwb_we", 32'(bus.MEMWB_RegWrite_o), 32'd0);
    end

    // load-use: one stall cycle, bubble, count
    set_in(1, 2, 8, 1, 1, 0, 0); step("t3_ld");
    set_in(0, 8, 9, 1, 0, 0, 0);
    chk("t3_stall_hi", 32'(bus.Stall_o), 32'd1);
    step("t3_use");
    chk("t3_idex_rt0", 32'(bus.IDEX_RegRT_o), 32'd0);
    chk("t3_lu_cnt",   32'(bus.LoadUseCnt_o), 32'd1);
    chk("t3_stall_lo", 32'(bus.Stall_o), 32'd0);
    step("t3_go");

    // flush beats load-use
    set_in(1, 2, 8, 1, 1, 0, 0); step("t4_ld");
    set_in(0, 8, 9, 1, 0, 1, 0);
    chk("t4_stall", 32'(bus.Stall_o), 32'd0);
    step("t4_fl");
    chk("t4_idex_rt0", 32'(bus.IDEX_RegRT_o), 32'd0);
    chk("t4_lu_cnt",   32'(bus.LoadUseCnt_o), 32'd1);

    // memory freeze during a load-use
    set_in(1, 2, 8, 1, 1, 0, 0); step("t5_ld");
    set_in(0, 8, 9, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_stall", 32'(bus.Stall_o), 32'd1);
      step("t5_frz");
      chk("t5_idex_rt", 32'(bus.IDEX_RegRT_o), 32'd2);
    end
    chk("t5_ms_cnt", 32'(bus.MemStallCnt_o), 32'd3);
    chk("t5_lu_cnt", 32'(bus.LoadUseCnt_o), 32'd1);

    // narrow counter saturates at 3
    step("t6_sat");
    chk("t6_ms_cnt",   32'(bus.MemStallCnt_o), 32'd4);
    chk("t6_ms_cnt_s", 32'(bus_s.MemStallCnt_o), 32'd3);
    set_in(0, 8, 9, 1, 0, 0, 0); step("t6_lu");
    step("t6_go");

    // asynchronous reset between edges
    set_in(6, 7, 10, 1, 1, 0, 0); step("t7_a");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t7_rst");
    chk("t7_rst_stall", 32'(bus.Stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // random traffic, small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4,
             $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 2);
      step("rnd");
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
